// File: rtl/dec_scan_ctrl.sv
// Scan sequencer feeding a 4-to-16 decoder: walks sel through the channels, holding each unmasked one for DWELL cycles.
// Optional macro DEC_SCAN_DIR_EN adds a dir input that selects a descending scan order.
module dec_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic        stop,
  input  logic [15:0] mask,
`ifdef DEC_SCAN_DIR_EN
  input  logic        dir,
`endif
  output logic [3:0]  sel,
  output logic        en,
  output logic        busy,
  output logic        done
);

  // The NEXT step is folded into the last HOLD cycle of each channel, so only two states are stored.
  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      mask_q, mask_d;
  logic             cont_q, cont_d;

  logic [3:0] first_sel;
  logic [3:0] last_sel;
  logic [3:0] step_sel;

`ifdef DEC_SCAN_DIR_EN
  logic dir_q, dir_d;

  assign first_sel = dir ? 4'hF : 4'h0;
  assign last_sel  = dir_q ? 4'h0 : 4'hF;
  assign step_sel  = dir_q ? sel_q - 4'd1 : sel_q + 4'd1;
`else
  assign first_sel = 4'h0;
  assign last_sel  = 4'hF;
  assign step_sel  = sel_q + 4'd1;
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through the case can infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
`ifdef DEC_SCAN_DIR_EN
    dir_d   = dir_q;
`endif

    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          mask_d  = mask;
          cont_d  = cont;
`ifdef DEC_SCAN_DIR_EN
          dir_d   = dir;
`endif
          sel_d   = first_sel;
          en_d    = mask[first_sel];
          cnt_d   = mask[first_sel] ? LOAD : '0;
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (sel_q == last_sel && (!cont_q || stop)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          // Wrap at the pass boundary falls out of the 4-bit step arithmetic.
          sel_d = step_sel;
          en_d  = mask_q[step_sel];
          cnt_d = mask_q[step_sel] ? LOAD : '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 4'h0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
`ifdef DEC_SCAN_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
`ifdef DEC_SCAN_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench for dec_scan_ctrl: stimulus queues the expected per-cycle outputs, a negedge monitor compares them.
module tb_dec_scan_ctrl;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont;
  logic        stop;
  logic [15:0] mask;
`ifdef DEC_SCAN_DIR_EN
  logic        dir;
`endif
  logic [3:0]  sel;
  logic        en;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en;
    logic [3:0] sel;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dec_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cont  (cont),
    .stop  (stop),
    .mask  (mask),
`ifdef DEC_SCAN_DIR_EN
    .dir   (dir),
`endif
    .sel   (sel),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected trace of one pass: DWELL cycles per unmasked channel, one cycle per masked channel.
  task automatic push_pass(input logic [15:0] m, input logic desc, input logic end_done);
    obs_t o;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      c = desc ? 4'(15 - i) : 4'(i);
      o = '{busy: 1'b1, done: 1'b0, en: m[c], sel: c};
      if (m[c]) begin
        for (int k = 0; k < DWELL; k++) exp_q.push_back(o);
      end else begin
        exp_q.push_back(o);
      end
    end
    if (end_done) exp_q.push_back('{busy: 1'b0, done: 1'b1, en: 1'b0, sel: desc ? 4'h0 : 4'hF});
  endtask

  task automatic issue_start(input logic [15:0] m, input logic c, input logic d);
    @(negedge clk); #1;
    mask  = m;
    cont  = c;
`ifdef DEC_SCAN_DIR_EN
    dir   = d;
`else
    if (d) $display("note: descending order requested without the dir option");
`endif
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int left;
    left = budget;
    while (exp_q.size() != 0 && left > 0) begin
      @(negedge clk); #1;
      left--;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 16'(exp_q.size()), 16'h0);
      exp_q.delete();
    end
  endtask

  // Monitor: every cycle with busy or done must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (!busy) check("en_outside_busy", 16'(en), 16'h0);
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 16'({busy, done, en, sel}), 16'h0);
        end else begin
          obs_t e;
          e = exp_q.pop_front();
          check("scan_output", 16'({busy, done, en, sel}), 16'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    stop  = 1'b0;
    mask  = 16'h0;
`ifdef DEC_SCAN_DIR_EN
    dir   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", 16'({busy, done, en, sel}), 16'h0);
    #1 rst = 1'b0;

    // Full ascending pass: 64 busy cycles, then done at sel 15.
    push_pass(16'hFFFF, 1'b0, 1'b1);
    issue_start(16'hFFFF, 1'b0, 1'b0);
    wait_drain(200);

    // Sparse mask restarted the cycle after done: 4 + 14 + 4 = 22 busy cycles.
    push_pass(16'h8001, 1'b0, 1'b1);
    issue_start(16'h8001, 1'b0, 1'b0);
    wait_drain(100);

    // Empty mask with start held high for the whole pass, including the done edge.
    push_pass(16'h0000, 1'b0, 1'b1);
    @(negedge clk); #1;
    mask  = 16'h0000;
    cont  = 1'b0;
    start = 1'b1;
    wait_drain(60);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_empty", 16'({busy, en}), 16'h0);

    // Continuous: pass 1 wraps with no done, stop during pass 2 ends it at sel 15; a mid-scan start is ignored.
    push_pass(16'hFFFF, 1'b0, 1'b0);
    push_pass(16'hFFFF, 1'b0, 1'b1);
    issue_start(16'hFFFF, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    #1;
    mask  = 16'h0000;
    cont  = 1'b0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (50) @(negedge clk);
    #1 stop = 1'b1;
    wait_drain(200);
    stop = 1'b0;

`ifdef DEC_SCAN_DIR_EN
    // Descending pass ends with done at sel 0; ascending with dir=0 matches the plain build.
    push_pass(16'hFFFF, 1'b1, 1'b1);
    issue_start(16'hFFFF, 1'b0, 1'b1);
    wait_drain(200);
    push_pass(16'hFFFF, 1'b0, 1'b1);
    issue_start(16'hFFFF, 1'b0, 1'b0);
    wait_drain(200);
`endif

    // Asynchronous reset while channel 7 is being held.
    push_pass(16'hFFFF, 1'b0, 1'b1);
    issue_start(16'hFFFF, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    #2;
    check("pre_reset_sel", 16'({busy, sel}), 16'({1'b1, 4'd7}));
    rst = 1'b1;
    #1;
    check("reset_async", 16'({busy, done, en, sel}), 16'h0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_reset", 16'({busy, en, sel}), 16'h0);

    // A fresh start after reset scans normally from channel 0.
    push_pass(16'h00F0, 1'b0, 1'b1);
    issue_start(16'h00F0, 1'b0, 1'b0);
    wait_drain(100);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
